// File: rtl/tcp_tx_rt_timer.sv
// Per-flow TCP retransmission timer: tracks armed flows against a free-running
// cycle counter and issues one timeout or fast-retransmit request at a time.
module tcp_tx_rt_timer #(
  parameter int unsigned NUM_FLOWS      = 8,
  parameter int unsigned FLOWID_W       = $clog2(NUM_FLOWS),
  parameter int unsigned TIMESTAMP_W    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 250000000,
  parameter int unsigned DUP_ACK_CNT_W  = 4,
  parameter int unsigned DUP_ACK_RT     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm_val,
  input  logic [FLOWID_W-1:0]      arm_flowid,
  output logic                     arm_rdy,
  input  logic                     ack_val,
  input  logic [FLOWID_W-1:0]      ack_flowid,
  input  logic                     ack_all_acked,
  input  logic [DUP_ACK_CNT_W-1:0] ack_dup_cnt,
  output logic                     ack_rdy,
  output logic                     rt_req_val,
  output logic [FLOWID_W-1:0]      rt_req_flowid,
  output logic                     rt_req_fast,
  input  logic                     rt_req_rdy
);

  localparam logic [0:0] SCAN = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  localparam logic [TIMESTAMP_W-1:0]   TIMEOUT   = TIMESTAMP_W'(TIMEOUT_CYCLES);
  localparam logic [DUP_ACK_CNT_W-1:0] DUP_RT    = DUP_ACK_CNT_W'(DUP_ACK_RT);
  localparam logic [FLOWID_W-1:0]      LAST_FLOW = FLOWID_W'(NUM_FLOWS - 1);

  logic [TIMESTAMP_W-1:0] now_q, now_d;
  logic [TIMESTAMP_W-1:0] ts_q [NUM_FLOWS];
  logic [TIMESTAMP_W-1:0] ts_d [NUM_FLOWS];
  logic [NUM_FLOWS-1:0]   armed_q, armed_d;
  logic [NUM_FLOWS-1:0]   fast_q, fast_d;
  logic [FLOWID_W-1:0]    scan_ptr_q, scan_ptr_d;
  logic [0:0]             state_q, state_d;
  logic [FLOWID_W-1:0]    req_flowid_q, req_flowid_d;
  logic                   req_fast_q, req_fast_d;

  logic                   hs;
  logic                   fast_found;
  logic [FLOWID_W-1:0]    fast_idx;
  logic [TIMESTAMP_W-1:0] ptr_age;
  logic                   ptr_expired;

  function automatic logic [FLOWID_W-1:0] next_flow(input logic [FLOWID_W-1:0] f);
    return (f == LAST_FLOW) ? '0 : f + 1'b1;
  endfunction

  assign arm_rdy       = 1'b1;
  assign ack_rdy       = 1'b1;
  assign rt_req_val    = (state_q == REQ);
  assign rt_req_flowid = req_flowid_q;
  assign rt_req_fast   = req_fast_q;

  assign hs          = (state_q == REQ) && rt_req_rdy;
  assign ptr_age     = now_q - ts_q[scan_ptr_q];
  assign ptr_expired = armed_q[scan_ptr_q] && (ptr_age >= TIMEOUT);
  assign now_d       = now_q + 1'b1;

  // Lowest-indexed flow with a pending fast retransmit wins.
  always_comb begin
    fast_found = 1'b0;
    fast_idx   = '0;
    for (int unsigned i = 0; i < NUM_FLOWS; i++) begin
      if (fast_q[i] && !fast_found) begin
        fast_found = 1'b1;
        fast_idx   = FLOWID_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    scan_ptr_d   = scan_ptr_q;
    req_flowid_d = req_flowid_q;
    req_fast_d   = req_fast_q;
    case (state_q)
      SCAN: begin
        if (fast_found) begin
          req_flowid_d = fast_idx;
          req_fast_d   = 1'b1;
          state_d      = REQ;
        end else if (ptr_expired) begin
          req_flowid_d = scan_ptr_q;
          req_fast_d   = 1'b0;
          state_d      = REQ;
        end else begin
          scan_ptr_d = next_flow(scan_ptr_q);
        end
      end
      REQ: begin
        if (rt_req_rdy) begin
          state_d = SCAN;
          if (!req_fast_q) scan_ptr_d = next_flow(req_flowid_q);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // Per-flow updates are layered so later sources override earlier ones:
  // handshake restart, then ACK, then arm (which sees the post-ACK armed bit).
  always_comb begin
    armed_d = armed_q;
    fast_d  = fast_q;
    for (int unsigned i = 0; i < NUM_FLOWS; i++) begin
      ts_d[i] = ts_q[i];
      if (hs && (req_flowid_q == FLOWID_W'(i))) begin
        if (req_fast_q) fast_d[i] = 1'b0;
        if (armed_q[i]) ts_d[i] = now_q;
      end
      if (ack_val && (ack_flowid == FLOWID_W'(i))) begin
        if (ack_all_acked) begin
          armed_d[i] = 1'b0;
          fast_d[i]  = 1'b0;
        end else begin
          if (armed_q[i]) ts_d[i] = now_q;
          if (ack_dup_cnt == DUP_RT) fast_d[i] = 1'b1;
        end
      end
      if (arm_val && (arm_flowid == FLOWID_W'(i)) && !armed_d[i]) begin
        armed_d[i] = 1'b1;
        ts_d[i]    = now_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      now_q        <= '0;
      armed_q      <= '0;
      fast_q       <= '0;
      scan_ptr_q   <= '0;
      state_q      <= SCAN;
      req_flowid_q <= '0;
      req_fast_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_FLOWS; i++) ts_q[i] <= '0;
    end else begin
      now_q        <= now_d;
      armed_q      <= armed_d;
      fast_q       <= fast_d;
      scan_ptr_q   <= scan_ptr_d;
      state_q      <= state_d;
      req_flowid_q <= req_flowid_d;
      req_fast_q   <= req_fast_d;
      for (int unsigned i = 0; i < NUM_FLOWS; i++) ts_q[i] <= ts_d[i];
    end
  end

endmodule

// File: tb/tb_tcp_tx_rt_timer.sv
// Scoreboard bench for tcp_tx_rt_timer: a behavioural model predicts every
// retransmit request (flow, kind, first cycle) and a monitor checks the DUT.
module tb_tcp_tx_rt_timer;
  localparam int N   = 8;
  localparam int FW  = 3;
  localparam int TW  = 12;
  localparam int MOD = 1 << TW;
  localparam int TO  = 100;
  localparam int RT  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arm_val = 1'b0;
  logic [FW-1:0] arm_flowid = '0;
  logic arm_rdy;
  logic ack_val = 1'b0;
  logic [FW-1:0] ack_flowid = '0;
  logic ack_all_acked = 1'b0;
  logic [3:0] ack_dup_cnt = '0;
  logic ack_rdy;
  logic rt_req_val;
  logic [FW-1:0] rt_req_flowid;
  logic rt_req_fast;
  logic rt_req_rdy = 1'b0;

  tcp_tx_rt_timer #(
    .NUM_FLOWS(N), .FLOWID_W(FW), .TIMESTAMP_W(TW),
    .TIMEOUT_CYCLES(TO), .DUP_ACK_CNT_W(4), .DUP_ACK_RT(RT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .arm_val(arm_val), .arm_flowid(arm_flowid), .arm_rdy(arm_rdy),
    .ack_val(ack_val), .ack_flowid(ack_flowid), .ack_all_acked(ack_all_acked),
    .ack_dup_cnt(ack_dup_cnt), .ack_rdy(ack_rdy),
    .rt_req_val(rt_req_val), .rt_req_flowid(rt_req_flowid),
    .rt_req_fast(rt_req_fast), .rt_req_rdy(rt_req_rdy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { int flow; int fast; int cyc; } exp_t;
  exp_t exp_q[$];

  int  m_now, m_ptr, m_flow, m_fast, m_req;
  int  m_ts [N];
  int  m_armed [N];
  int  m_fp [N];
  int  m_hs, m_pick, m_age;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_now = 0; m_ptr = 0; m_req = 0; m_flow = 0; m_fast = 0;
      for (int i = 0; i < N; i++) begin m_ts[i] = 0; m_armed[i] = 0; m_fp[i] = 0; end
      exp_q.delete();
    end else begin
      m_hs = m_req && rt_req_rdy;
      if (!m_req) begin
        m_pick = -1;
        for (int i = N - 1; i >= 0; i--) if (m_fp[i] != 0) m_pick = i;
        m_age = (m_now - m_ts[m_ptr] + MOD) % MOD;
        if (m_pick >= 0) begin
          m_req = 1; m_flow = m_pick; m_fast = 1;
          exp_q.push_back('{m_pick, 1, cyc});
        end else if (m_armed[m_ptr] != 0 && m_age >= TO) begin
          m_req = 1; m_flow = m_ptr; m_fast = 0;
          exp_q.push_back('{m_ptr, 0, cyc});
        end else m_ptr = (m_ptr + 1) % N;
      end else if (m_hs != 0) begin
        m_req = 0;
        if (m_fast == 0) m_ptr = (m_flow + 1) % N;
      end
      if (m_hs != 0) begin
        if (m_fast != 0) m_fp[m_flow] = 0;
        if (m_armed[m_flow] != 0) m_ts[m_flow] = m_now;
      end
      if (ack_val) begin
        if (ack_all_acked) begin
          m_armed[ack_flowid] = 0; m_fp[ack_flowid] = 0;
        end else begin
          if (m_armed[ack_flowid] != 0) m_ts[ack_flowid] = m_now;
          if (int'(ack_dup_cnt) == RT) m_fp[ack_flowid] = 1;
        end
      end
      if (arm_val && m_armed[arm_flowid] == 0) begin
        m_armed[arm_flowid] = 1; m_ts[arm_flowid] = m_now;
      end
      m_now = (m_now + 1) % MOD;
    end
  end

  // ---------------- monitor ----------------
  bit seen = 0;
  int cap_flow, cap_fast;
  exp_t e;

  always @(negedge clk) begin
    if (!rst_n) seen = 0;
    else if (rt_req_val) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got flow %0d fast %0d expected none (cycle %0d)",
                   rt_req_flowid, rt_req_fast, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("req_flowid", int'(rt_req_flowid), e.flow);
          chk("req_fast", int'(rt_req_fast), e.fast);
          chk("req_cycle", cyc, e.cyc);
        end
        seen = 1; cap_flow = int'(rt_req_flowid); cap_fast = int'(rt_req_fast);
      end else begin
        chk("stable_flowid", int'(rt_req_flowid), cap_flow);
        chk("stable_fast", int'(rt_req_fast), cap_fast);
      end
      if (rt_req_rdy) seen = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
    arm_val = 1'b0; ack_val = 1'b0;
  endtask

  task automatic arm(input int f);
    arm_val = 1'b1; arm_flowid = FW'(f); step();
  endtask

  task automatic ack(input int f, input bit all, input int dup);
    ack_val = 1'b1; ack_flowid = FW'(f); ack_all_acked = all; ack_dup_cnt = 4'(dup); step();
  endtask

  task automatic wait_req(input int max, output int app);
    app = -1;
    for (int i = 0; i < max; i++) begin
      if (rt_req_val) begin app = cyc; return; end
      step();
    end
    checks++; errors++;
    $display("FAIL wait_req: got no request expected one within %0d cycles", max);
  endtask

  int k, app, hs_c, cnt;
  int order[$];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Timeout on flow 2 with a held request
    rt_req_rdy = 1'b0;
    arm(2); k = cyc;
    wait_req(200, app);
    chk_range("timeout_window", app - k, TO, TO + N);
    repeat (5) step();
    rt_req_rdy = 1'b1; step(); hs_c = cyc; rt_req_rdy = 1'b0;
    wait_req(200, app);
    chk_range("timeout_regap", app - hs_c, TO, TO + 2 * N);

    // Async reset while the request is held
    @(posedge clk); #2; rst_n = 1'b0; #1;
    chk("reset_val_drop", int'(rt_req_val), 0);
    step(); step(); rst_n = 1'b1; #1;
    chk("reset_val", int'(rt_req_val), 0);
    chk("reset_flowid", int'(rt_req_flowid), 0);
    chk("reset_fast", int'(rt_req_fast), 0);
    chk("arm_rdy", int'(arm_rdy), 1);
    chk("ack_rdy", int'(ack_rdy), 1);
    cnt = 0;
    repeat (500) begin step(); if (rt_req_val) cnt++; end
    chk("reset_quiet", cnt, 0);

    // Disarm
    rt_req_rdy = 1'b1;
    arm(1); repeat (49) step(); ack(1, 1'b1, 0);
    cnt = 0;
    repeat (300) begin step(); if (rt_req_val) cnt++; end
    chk("disarm_quiet", cnt, 0);

    // Restart by non-final ACKs
    arm(3); cnt = 0;
    repeat (5) begin
      repeat (59) begin step(); if (rt_req_val) cnt++; end
      ack(3, 1'b0, 0);
    end
    k = cyc;
    chk("restart_quiet", cnt, 0);
    wait_req(150, app);
    chk_range("restart_window", app - k, TO, TO + N);
    step(); ack(3, 1'b1, 0);
    repeat (5) step();

    // Fast retransmit
    arm(5); repeat (3) step();
    ack(5, 1'b0, RT); k = cyc;
    step();
    chk("fast_val", int'(rt_req_val), 1);
    chk("fast_flowid", int'(rt_req_flowid), 5);
    chk("fast_kind", int'(rt_req_fast), 1);
    step();
    ack(5, 1'b0, RT + 1);
    cnt = 0;
    repeat (20) begin step(); if (rt_req_val) cnt++; end
    chk("dup_above_quiet", cnt, 0);
    ack(5, 1'b1, 0);
    repeat (5) step();

    // Priority among pending fast retransmits
    rt_req_rdy = 1'b0;
    ack(0, 1'b0, RT); repeat (3) step();
    ack(6, 1'b0, RT); ack(4, 1'b0, RT); repeat (3) step();
    rt_req_rdy = 1'b1; order.delete();
    repeat (12) begin if (rt_req_val) order.push_back(int'(rt_req_flowid)); step(); end
    chk("prio_count", order.size(), 3);
    if (order.size() == 3) begin
      chk("prio_first", order[0], 0);
      chk("prio_second", order[1], 4);
      chk("prio_third", order[2], 6);
    end

    // Fast pending cancelled by all_acked before issue
    rt_req_rdy = 1'b0;
    ack(0, 1'b0, RT); repeat (3) step();
    ack(6, 1'b0, RT); ack(6, 1'b1, 0);
    rt_req_rdy = 1'b1; cnt = 0;
    repeat (12) begin if (rt_req_val && rt_req_flowid == 3'd6) cnt++; step(); end
    chk("cancel_flow6", cnt, 0);

    // Randomised traffic
    for (int i = 0; i < 20000; i++) begin
      rt_req_rdy = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 8) begin
        arm_val = 1'b1; arm_flowid = FW'($urandom_range(0, N - 1));
      end
      if ($urandom_range(0, 99) < 6) begin
        ack_val = 1'b1; ack_flowid = FW'($urandom_range(0, N - 1));
        ack_all_acked = ($urandom_range(0, 3) == 0);
        ack_dup_cnt = 4'($urandom_range(0, 5));
      end
      step();
    end

    // Drain: disarm everything and let any in-flight request complete
    rt_req_rdy = 1'b1;
    for (int f = 0; f < N; f++) ack(f, 1'b1, 0);
    repeat (30) step();
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
